// File: rtl/gain_ctrl_pkg.sv
// gain_ctrl_pkg: shared types and register map for the gain ramp controller
//   state_t    : sequencer states (INIT loads the reset coef, IDLE waits, RAMP steps toward target)
//   ADDR_*     : Avalon-MM register addresses
//   CTRL_*     : bit positions in a CTRL write
//   STAT_*     : bit positions in a STATUS read
package gain_ctrl_pkg;
   typedef enum logic [1:0] {INIT, IDLE, RAMP} state_t;
   localparam logic [1:0] ADDR_TARGET = 2'd0;
   localparam logic [1:0] ADDR_STEP   = 2'd1;
   localparam logic [1:0] ADDR_SPS    = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;
   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_DONE_CLR = 2;
   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
endpackage

// File: rtl/gain_step_calc.sv
// gain_step_calc: one saturating step of cur toward tgt by at most stp
//   i_cur  : current coef (signed)
//   i_tgt  : target coef (signed)
//   i_stp  : step size (unsigned, one bit narrower than coef)
//   o_next : next coef; equals i_tgt when within one step or when i_stp is zero
module gain_step_calc #(
   parameter int COEF_WDT = 16
)(
   input  logic signed [COEF_WDT-1:0] i_cur,
   input  logic signed [COEF_WDT-1:0] i_tgt,
   input  logic        [COEF_WDT-2:0] i_stp,
   output logic signed [COEF_WDT-1:0] o_next
);
   logic signed [COEF_WDT:0] w_cur_x;
   logic signed [COEF_WDT:0] w_stp_x;
   logic signed [COEF_WDT:0] w_diff;
   logic        [COEF_WDT:0] w_mag;
   logic                     w_snap;
   // One extra bit keeps the difference of two full-range coefs from wrapping
   always_comb begin
      w_cur_x = (COEF_WDT+1)'(i_cur);
      w_stp_x = signed'({2'b00, i_stp});
      w_diff  = (COEF_WDT+1)'(i_tgt) - w_cur_x;
      w_mag   = w_diff[COEF_WDT] ? unsigned'(-w_diff) : unsigned'(w_diff);
      w_snap  = (i_stp == '0) || (w_mag <= unsigned'(w_stp_x));
      // When not snapping, |diff| > stp so cur +/- stp stays strictly inside [cur, tgt]
      o_next  = w_snap ? i_tgt : COEF_WDT'(w_diff[COEF_WDT] ? w_cur_x - w_stp_x : w_cur_x + w_stp_x);
   end
endmodule

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: ramps the gain block coef toward a CPU-programmed target, one step per N samples
//   csi_clk/rsi_reset_n : clock, synchronous active-low reset
//   avs_*               : Avalon-MM slave; 0 TARGET, 1 STEP, 2 SPS, 3 CTRL(w)/STATUS(r); readdata registered
//   smp_valid           : sample strobe that paces the ramp
//   coef_write/_writedata : one-cycle coef write to the gain block, sign-extended to 32 bits
//   busy                : high while ramping
//   irq                 : one-cycle pulse when the target is reached
module gain_ramp_ctrl
   import gain_ctrl_pkg::*;
#(
   parameter int COEF_WDT  = 16,
   parameter int CNT_WDT   = 16,
   parameter int COEF_INIT = 2**(COEF_WDT-2)
)(
   input  logic        csi_clk,
   input  logic        rsi_reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic        avs_read,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   input  logic        smp_valid,
   output logic        coef_write,
   output logic [31:0] coef_writedata,
   output logic        busy,
   output logic        irq
);
   localparam logic signed [COEF_WDT-1:0] INIT_C = COEF_WDT'(COEF_INIT);
   state_t                      r_state;
   logic signed [COEF_WDT-1:0]  r_target;
   logic        [COEF_WDT-2:0]  r_step;
   logic        [CNT_WDT-1:0]   r_sps;
   logic signed [COEF_WDT-1:0]  r_tgt;
   logic        [COEF_WDT-2:0]  r_stp;
   logic        [CNT_WDT-1:0]   r_sps_l;
   logic        [CNT_WDT-1:0]   r_cnt;
   logic signed [COEF_WDT-1:0]  r_cur;
   logic                        r_fin;
   logic                        r_done;
   logic signed [COEF_WDT-1:0]  w_next;
   logic                        w_ctrl_wr;
   logic                        w_start;
   logic                        w_abort;
   logic                        w_clr;
   logic                        w_last;
   logic [31:0]                 w_rdata;
   logic                        w_unused;
   gain_step_calc #(.COEF_WDT(COEF_WDT)) u_step (
      .i_cur  (r_cur),
      .i_tgt  (r_tgt),
      .i_stp  (r_stp),
      .o_next (w_next)
   );
   assign w_unused = ^avs_writedata;
   always_comb begin
      w_ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
      w_abort   = w_ctrl_wr && avs_writedata[CTRL_ABORT];
      w_start   = w_ctrl_wr && avs_writedata[CTRL_START] && !avs_writedata[CTRL_ABORT];
      w_clr     = w_ctrl_wr && avs_writedata[CTRL_DONE_CLR];
      // SPS of 0 behaves as 1: every sample is a step boundary
      w_last    = (r_sps_l <= CNT_WDT'(1)) || (r_cnt == r_sps_l - CNT_WDT'(1));
      w_rdata   = (avs_address == ADDR_TARGET) ? 32'(r_target) :
                  (avs_address == ADDR_STEP)   ? 32'(r_step)   :
                  (avs_address == ADDR_SPS)    ? 32'(r_sps)    :
                  {30'd0, r_done, busy};
   end
   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         r_state        <= INIT;
         r_target       <= INIT_C;
         r_step         <= '0;
         r_sps          <= '0;
         r_tgt          <= INIT_C;
         r_stp          <= '0;
         r_sps_l        <= '0;
         r_cnt          <= '0;
         r_cur          <= INIT_C;
         r_fin          <= 1'b0;
         r_done         <= 1'b0;
         avs_readdata   <= '0;
         coef_write     <= 1'b0;
         coef_writedata <= '0;
         busy           <= 1'b0;
         irq            <= 1'b0;
      end else begin
         coef_write <= 1'b0;
         irq        <= 1'b0;
         if (avs_write && avs_address == ADDR_TARGET) r_target <= avs_writedata[COEF_WDT-1:0];
         if (avs_write && avs_address == ADDR_STEP)   r_step   <= avs_writedata[COEF_WDT-2:0];
         if (avs_write && avs_address == ADDR_SPS)    r_sps    <= avs_writedata[CNT_WDT-1:0];
         if (avs_read) avs_readdata <= w_rdata;
         // A completion later in this block overrides the clear, so done stays set
         if (w_clr) r_done <= 1'b0;
         case (r_state)
            INIT: begin
               coef_write     <= 1'b1;
               coef_writedata <= 32'(INIT_C);
               r_state        <= IDLE;
            end
            IDLE: begin
               if (w_start) begin
                  r_tgt   <= r_target;
                  r_stp   <= r_step;
                  r_sps_l <= r_sps;
                  r_cnt   <= '0;
                  r_fin   <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= RAMP;
               end
            end
            RAMP: begin
               if (w_abort) begin
                  r_fin   <= 1'b0;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else if (w_start) begin
                  r_tgt   <= r_target;
                  r_stp   <= r_step;
                  r_sps_l <= r_sps;
                  r_cnt   <= '0;
                  r_fin   <= 1'b0;
               end else if (r_fin) begin
                  // Target reached on the previous step; its write (if any) has gone out
                  r_fin   <= 1'b0;
                  r_done  <= 1'b1;
                  irq     <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else if (smp_valid) begin
                  if (w_last) begin
                     r_cnt <= '0;
                     r_fin <= (w_next == r_tgt);
                     if (w_next != r_cur) begin
                        r_cur          <= w_next;
                        coef_write     <= 1'b1;
                        coef_writedata <= 32'(w_next);
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_WDT'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
